// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmit path: parity codes,
// transmitter FSM states, default sizing and the parity-mode decoder.
package uart_tx_buffered_pkg;

    localparam int unsigned UART_DEF_FIFO_DEPTH = 16;
    localparam int unsigned UART_DEF_DIV_WIDTH  = 16;

    typedef enum logic [2:0] {
        UART_PAR_NONE  = 3'd0,
        UART_PAR_ODD   = 3'd1,
        UART_PAR_EVEN  = 3'd2,
        UART_PAR_MARK  = 3'd3,
        UART_PAR_SPACE = 3'd4
    } uart_par_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_BREAK  = 3'd5
    } tx_state_e;

    // Unused codes 5..7 fall back to no parity.
    function automatic uart_par_e uart_par_decode(input logic [2:0] code);
        case (code)
            3'd1:    return UART_PAR_ODD;
            3'd2:    return UART_PAR_EVEN;
            3'd3:    return UART_PAR_MARK;
            3'd4:    return UART_PAR_SPACE;
            default: return UART_PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and an explicit occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned P_WIDTH = 8,
    parameter int unsigned P_DEPTH = 16,
    localparam int unsigned AW = $clog2(P_DEPTH),
    localparam int unsigned LW = $clog2(P_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] pop_data,
    output logic [LW-1:0]      level,
    output logic               full,
    output logic               empty
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (level == LW'(P_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign pop_data = mem[rd_ptr];

    // Storage write port; no reset needed on the data array.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and level bookkeeping; flush and reset both empty the FIFO.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a push FIFO feeding a runtime-configurable
// serialiser (divisor, data bits, parity, stop bits, break).
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned P_SYSTEM_CLK      = 50000000,
    parameter int unsigned P_UART_BUADRATE   = 115200,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_FIFO_DEPTH      = UART_DEF_FIFO_DEPTH,
    parameter int unsigned P_DIV_WIDTH       = UART_DEF_DIV_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [P_UART_DATA_WIDTH-1:0]       i_user_tx_data,
    input  logic                               i_user_tx_valid,
    output logic                               o_user_tx_ready,
    input  logic [P_DIV_WIDTH-1:0]             i_cfg_div,
    input  logic [3:0]                         i_cfg_data_bits,
    input  logic [2:0]                         i_cfg_parity,
    input  logic                               i_cfg_stop2,
    input  logic                               i_cfg_break,
    input  logic                               i_flush,
    output logic                               o_uart_tx,
    output logic                               o_tx_busy,
    output logic                               o_frame_done,
    output logic [$clog2(P_FIFO_DEPTH):0]      o_fifo_level
);

    localparam int unsigned W = P_UART_DATA_WIDTH;
    localparam logic [P_DIV_WIDTH-1:0] DIV_RST  = P_DIV_WIDTH'(P_SYSTEM_CLK / P_UART_BUADRATE);
    localparam logic [P_DIV_WIDTH-1:0] DIV_ONE  = P_DIV_WIDTH'(1);
    localparam logic [P_DIV_WIDTH-1:0] DIV_MIN  = P_DIV_WIDTH'(2);
    localparam logic [3:0]             MAX_BITS = 4'(P_UART_DATA_WIDTH);

    tx_state_e          state;
    tx_state_e          state_nxt;
    logic               line_nxt;
    logic               tx;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [W-1:0]       pop_data;

    logic [P_DIV_WIDTH-1:0] div_eff;
    logic [3:0]         bits_eff;
    uart_par_e          par_mode;
    logic [W-1:0]       data_mask;
    logic [W-1:0]       data_masked;
    logic               par_en_eff;
    logic               par_bit_eff;

    logic [P_DIV_WIDTH-1:0] cnt;
    logic [P_DIV_WIDTH-1:0] div_l;
    logic [3:0]         bits_l;
    logic [3:0]         bit_idx;
    logic [W-1:0]       shift;
    logic               par_en_l;
    logic               par_bit_l;
    logic               stop2_l;
    logic               stop_second;
    logic               brk_stop;

    logic               frame_start;
    logic               bit_end;
    logic               last_stop;

    assign o_user_tx_ready = ~reset & ~fifo_full & ~i_flush;
    assign fifo_push       = i_user_tx_valid & o_user_tx_ready;
    assign o_uart_tx       = tx;
    assign o_tx_busy       = (state != TX_IDLE);
    assign bit_end         = (cnt == '0);
    assign last_stop       = ~stop2_l | stop_second | brk_stop;
    assign o_frame_done    = (state == TX_STOP) & bit_end & last_stop & ~brk_stop;

    uart_sync_fifo #(
        .P_WIDTH (W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (i_flush),
        .push      (fifo_push),
        .push_data (i_user_tx_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .level     (o_fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sanitise the live configuration and precompute the frame's parity bit.
    always_comb begin
        div_eff  = (i_cfg_div < DIV_MIN) ? DIV_MIN : i_cfg_div;
        bits_eff = (i_cfg_data_bits < 4'd5 || i_cfg_data_bits > MAX_BITS) ? MAX_BITS : i_cfg_data_bits;
        par_mode = uart_par_decode(i_cfg_parity);
        data_mask = '0;
        for (int unsigned i = 0; i < W; i++) begin
            data_mask[i] = (4'(i) < bits_eff);
        end
        data_masked = pop_data & data_mask;
        par_en_eff  = (par_mode != UART_PAR_NONE);
        case (par_mode)
            UART_PAR_ODD:  par_bit_eff = ~(^data_masked);
            UART_PAR_EVEN: par_bit_eff = ^data_masked;
            UART_PAR_MARK: par_bit_eff = 1'b1;
            default:       par_bit_eff = 1'b0;
        endcase
    end

    // State register; the line is registered from the next-state value so
    // it changes in the same cycle the FSM enters a new bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= TX_IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            tx    <= line_nxt;
        end
    end

    // Next-state, next line level and FIFO pop decisions.
    always_comb begin
        state_nxt   = state;
        line_nxt    = 1'b1;
        fifo_pop    = 1'b0;
        frame_start = 1'b0;
        case (state)
            TX_IDLE: begin
                if (i_cfg_break) begin
                    state_nxt = TX_BREAK;
                    line_nxt  = 1'b0;
                end else if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    frame_start = 1'b1;
                    state_nxt   = TX_START;
                    line_nxt    = 1'b0;
                end
            end
            TX_START: begin
                line_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = TX_DATA;
                    line_nxt  = shift[0];
                end
            end
            TX_DATA: begin
                line_nxt = shift[0];
                if (bit_end) begin
                    if (bit_idx == bits_l - 4'd1) begin
                        if (par_en_l) begin
                            state_nxt = TX_PARITY;
                            line_nxt  = par_bit_l;
                        end else begin
                            state_nxt = TX_STOP;
                            line_nxt  = 1'b1;
                        end
                    end else begin
                        line_nxt = shift[1];
                    end
                end
            end
            TX_PARITY: begin
                line_nxt = par_bit_l;
                if (bit_end) begin
                    state_nxt = TX_STOP;
                    line_nxt  = 1'b1;
                end
            end
            TX_STOP: begin
                line_nxt = 1'b1;
                if (bit_end && last_stop) begin
                    if (!fifo_empty && !i_cfg_break) begin
                        fifo_pop    = 1'b1;
                        frame_start = 1'b1;
                        state_nxt   = TX_START;
                        line_nxt    = 1'b0;
                    end else begin
                        state_nxt = TX_IDLE;
                    end
                end
            end
            TX_BREAK: begin
                line_nxt = 1'b0;
                if (!i_cfg_break) begin
                    state_nxt = TX_STOP;
                    line_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
            end
        endcase
    end

    // Bit timer, data shifter and per-frame configuration latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            div_l       <= DIV_RST;
            bits_l      <= MAX_BITS;
            bit_idx     <= '0;
            shift       <= '0;
            par_en_l    <= 1'b0;
            par_bit_l   <= 1'b0;
            stop2_l     <= 1'b0;
            stop_second <= 1'b0;
            brk_stop    <= 1'b0;
        end else if (frame_start) begin
            cnt         <= div_eff - DIV_ONE;
            div_l       <= div_eff;
            bits_l      <= bits_eff;
            bit_idx     <= '0;
            shift       <= data_masked;
            par_en_l    <= par_en_eff;
            par_bit_l   <= par_bit_eff;
            stop2_l     <= i_cfg_stop2;
            stop_second <= 1'b0;
            brk_stop    <= 1'b0;
        end else begin
            case (state)
                TX_START, TX_PARITY: begin
                    cnt <= bit_end ? div_l - DIV_ONE : cnt - DIV_ONE;
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt     <= div_l - DIV_ONE;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 4'd1;
                    end else begin
                        cnt <= cnt - DIV_ONE;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt         <= div_l - DIV_ONE;
                        stop_second <= 1'b1;
                    end else begin
                        cnt <= cnt - DIV_ONE;
                    end
                end
                TX_BREAK: begin
                    // The post-break stop period always lasts one bit at the live divisor.
                    if (!i_cfg_break) begin
                        cnt      <= div_eff - DIV_ONE;
                        brk_stop <= 1'b1;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random
// frames, compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_buffered;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_user_tx_data;
    logic        i_user_tx_valid;
    logic        o_user_tx_ready;
    logic [15:0] i_cfg_div;
    logic [3:0]  i_cfg_data_bits;
    logic [2:0]  i_cfg_parity;
    logic        i_cfg_stop2;
    logic        i_cfg_break;
    logic        i_flush;
    logic        o_uart_tx;
    logic        o_tx_busy;
    logic        o_frame_done;
    logic [4:0]  o_fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    bit       exp_line[$];
    bit       exp_done[$];
    bit       exp_busy[$];
    logic [7:0] push_q[$];
    logic [7:0] acc_q[$];

    int flush_at      = -1;
    int flush_level   = 0;
    int cfg_change_at = -1;
    int new_div       = 0;

    uart_tx_buffered #(
        .P_SYSTEM_CLK      (50000000),
        .P_UART_BUADRATE   (115200),
        .P_UART_DATA_WIDTH (8),
        .P_FIFO_DEPTH      (16),
        .P_DIV_WIDTH       (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .i_user_tx_data  (i_user_tx_data),
        .i_user_tx_valid (i_user_tx_valid),
        .o_user_tx_ready (o_user_tx_ready),
        .i_cfg_div       (i_cfg_div),
        .i_cfg_data_bits (i_cfg_data_bits),
        .i_cfg_parity    (i_cfg_parity),
        .i_cfg_stop2     (i_cfg_stop2),
        .i_cfg_break     (i_cfg_break),
        .i_flush         (i_flush),
        .o_uart_tx       (o_uart_tx),
        .o_tx_busy       (o_tx_busy),
        .o_frame_done    (o_frame_done),
        .o_fifo_level    (o_fifo_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit stop2);
        i_cfg_div       = 16'(div);
        i_cfg_data_bits = 4'(bits);
        i_cfg_parity    = 3'(par);
        i_cfg_stop2     = stop2;
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_line.push_back(1'b1);
            exp_done.push_back(1'b0);
            exp_busy.push_back(1'b0);
        end
    endtask

    task automatic add_level(input bit lvl, input int n);
        for (int k = 0; k < n; k++) begin
            exp_line.push_back(lvl);
            exp_done.push_back(1'b0);
            exp_busy.push_back(1'b1);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s),
    // each symbol held for the effective divisor; done on the very last cycle.
    task automatic add_frame(input logic [7:0] d, input int div, input int bits,
                             input int par, input bit stop2);
        int dv;
        int nb;
        int ones;
        bit seq[$];
        dv   = (div < 2) ? 2 : div;
        nb   = (bits < 5 || bits > 8) ? 8 : bits;
        ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            seq.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (par)
            1: seq.push_back((ones % 2) == 0);
            2: seq.push_back((ones % 2) == 1);
            3: seq.push_back(1'b1);
            4: seq.push_back(1'b0);
            default: ;
        endcase
        seq.push_back(1'b1);
        if (stop2) seq.push_back(1'b1);
        for (int k = 0; k < seq.size(); k++) begin
            for (int c = 0; c < dv; c++) begin
                exp_line.push_back(seq[k]);
                exp_busy.push_back(1'b1);
                exp_done.push_back((k == seq.size() - 1) && (c == dv - 1));
            end
        end
    endtask

    // Drives queued pushes one per cycle and compares every cycle against
    // the expected stream; bounded by the stream length.
    task automatic run_stream();
        int i;
        i = 0;
        while (exp_line.size() > 0) begin
            if (push_q.size() > 0) begin
                i_user_tx_valid = 1'b1;
                i_user_tx_data  = push_q.pop_front();
                check("push_ready", o_user_tx_ready, 1);
            end else begin
                i_user_tx_valid = 1'b0;
                i_user_tx_data  = 8'($urandom);
            end
            if (i == cfg_change_at) i_cfg_div = 16'(new_div);
            if (i == flush_at) begin
                check("flush_level_before", o_fifo_level, flush_level);
                i_flush         = 1'b1;
                i_user_tx_valid = 1'b1;
                i_user_tx_data  = 8'($urandom);
                #1;
                check("flush_ready", o_user_tx_ready, 0);
            end
            tick();
            if (i == flush_at) begin
                i_flush = 1'b0;
                check("flush_level_after", o_fifo_level, 0);
            end
            check("line", o_uart_tx, exp_line.pop_front());
            check("frame_done", o_frame_done, exp_done.pop_front());
            check("busy", o_tx_busy, exp_busy.pop_front());
            i++;
        end
        i_user_tx_valid = 1'b0;
        check("end_level", o_fifo_level, 0);
        flush_at      = -1;
        cfg_change_at = -1;
    endtask

    initial begin
        int lvl;
        reset           = 1'b1;
        i_user_tx_data  = '0;
        i_user_tx_valid = 1'b0;
        i_cfg_break     = 1'b0;
        i_flush         = 1'b0;
        set_cfg(4, 8, 0, 0);

        // Reset state
        repeat (3) tick();
        check("rst_ready", o_user_tx_ready, 0);
        check("rst_line", o_uart_tx, 1);
        check("rst_level", o_fifo_level, 0);
        check("rst_busy", o_tx_busy, 0);
        check("rst_done", o_frame_done, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", o_user_tx_ready, 1);
        check("post_rst_line", o_uart_tx, 1);

        // 8N1 div 4, 0xA5
        set_cfg(4, 8, 0, 0);
        add_idle(1); add_frame(8'hA5, 4, 8, 0, 0); add_idle(3);
        push_q.push_back(8'hA5);
        run_stream();

        // 7 data bits, every parity mode, plus bit 7 ignored
        for (int p = 1; p <= 4; p++) begin
            set_cfg(4, 7, p, 0);
            add_idle(1); add_frame(8'h53, 4, 7, p, 0); add_idle(2);
            push_q.push_back(8'h53);
            run_stream();
        end
        set_cfg(4, 7, 2, 0);
        add_idle(1); add_frame(8'h53, 4, 7, 2, 0); add_idle(2);
        push_q.push_back(8'hD3);
        run_stream();

        // 8N2 div 3, three back-to-back frames
        set_cfg(3, 8, 0, 1);
        add_idle(1);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            push_q.push_back(w);
            add_frame(w, 3, 8, 0, 1);
        end
        add_idle(3);
        run_stream();

        // Break while filling the FIFO beyond its depth
        set_cfg(3, 8, 0, 0);
        i_cfg_break = 1'b1;
        tick();
        check("break_line", o_uart_tx, 0);
        check("break_busy", o_tx_busy, 1);
        lvl = 0;
        for (int k = 0; k < 17; k++) begin
            i_user_tx_valid = 1'b1;
            i_user_tx_data  = 8'($urandom);
            #1;
            check("break_ready", o_user_tx_ready, (lvl < 16) ? 1 : 0);
            if (lvl < 16) begin
                acc_q.push_back(i_user_tx_data);
                lvl++;
            end
            tick();
            check("break_fill_line", o_uart_tx, 0);
            check("break_fill_level", o_fifo_level, lvl);
        end
        i_user_tx_valid = 1'b0;
        check("full_level", o_fifo_level, 16);
        check("full_ready", o_user_tx_ready, 0);
        i_cfg_break = 1'b0;
        add_level(1'b1, 3);
        while (acc_q.size() > 0) add_frame(acc_q.pop_front(), 3, 8, 0, 0);
        add_idle(3);
        run_stream();

        // Flush mid-frame with level 5 and a simultaneous push
        set_cfg(4, 8, 0, 0);
        add_idle(1);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            push_q.push_back(w);
            if (k == 0) add_frame(w, 4, 8, 0, 0);
        end
        add_idle(4);
        flush_at    = 15;
        flush_level = 5;
        run_stream();

        // Reset during DATA
        set_cfg(4, 8, 0, 0);
        for (int k = 0; k < 3; k++) begin
            i_user_tx_valid = 1'b1;
            i_user_tx_data  = 8'h00;
            tick();
        end
        i_user_tx_valid = 1'b0;
        repeat (8) tick();
        check("pre_rst_busy", o_tx_busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_line", o_uart_tx, 1);
        check("mid_rst_level", o_fifo_level, 0);
        check("mid_rst_busy", o_tx_busy, 0);
        reset = 1'b0;
        tick();
        check("after_rst_ready", o_user_tx_ready, 1);
        add_idle(4);
        run_stream();

        // Divisor change mid-frame applies to the next frame only
        set_cfg(4, 8, 0, 0);
        add_idle(1);
        push_q.push_back(8'h3C); add_frame(8'h3C, 4, 8, 0, 0);
        push_q.push_back(8'hC3); add_frame(8'hC3, 7, 8, 0, 0);
        add_idle(3);
        cfg_change_at = 12;
        new_div       = 7;
        run_stream();

        // Randomized configurations and bursts
        for (int r = 0; r < 25; r++) begin
            int div;
            int bits;
            int par;
            bit s2;
            int n;
            div  = $urandom_range(0, 6);
            bits = $urandom_range(0, 15);
            par  = $urandom_range(0, 7);
            s2   = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 4);
            set_cfg(div, bits, par, s2);
            add_idle(1);
            for (int k = 0; k < n; k++) begin
                logic [7:0] w;
                w = 8'($urandom);
                push_q.push_back(w);
                add_frame(w, div, bits, par, s2);
            end
            add_idle(2);
            run_stream();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
